axi_lite_slave_regs: RTL and testbench



---
 rtl/axi_lite_slave_regs.sv | 155 +++++++++++++++
 tb/tb_axi_lite_slave_regs.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register bank: terminates AW/W/B and AR/R channels and maps them
// onto NUM_REGS 32-bit software-visible registers with byte-strobe writes.
// Register contents are exported flat on REG_OUT; REG_WR pulses for one cycle
// after a register has been written.
module axi_lite_slave_regs #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REGS  = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [REG_WIDTH-1:0]          AWADDR,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [REG_WIDTH-1:0]          WDATA,
  input  logic [REG_WIDTH/8-1:0]        WSTRB,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [REG_WIDTH-1:0]          ARADDR,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [REG_WIDTH-1:0]          RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RVALID,
  input  logic                          RREADY,
  output logic [NUM_REGS*REG_WIDTH-1:0] REG_OUT,
  output logic [NUM_REGS-1:0]           REG_WR
);

  localparam int                   STRB_W     = REG_WIDTH / 8;
  localparam int                   IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [REG_WIDTH-1:0] ADDR_LIMIT = REG_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0]           RESP_OKAY  = 2'b00;
  localparam logic [1:0]           RESP_SLVERR = 2'b10;

  logic                 aw_held, w_held;
  logic [REG_WIDTH-1:0] aw_addr_q;
  logic [REG_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]    w_strb_q;
  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic                 bvalid_q, rvalid_q;
  logic [1:0]           bresp_q, rresp_q;
  logic [REG_WIDTH-1:0] rdata_q;
  logic [NUM_REGS-1:0]  reg_wr_q;

  logic                 aw_hs, w_hs, ar_hs, commit;
  logic                 wr_in_range, rd_in_range;
  logic [IDX_W-1:0]     wr_idx, rd_idx;

  // READYs are held low while in reset so nothing is accepted during it.
  assign AWREADY = !ARESET && !aw_held && !bvalid_q;
  assign WREADY  = !ARESET && !w_held  && !bvalid_q;
  assign ARREADY = !ARESET && !rvalid_q;

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID  && WREADY;
  assign ar_hs  = ARVALID && ARREADY;
  assign commit = aw_held && w_held;

  // Index is only meaningful when in range; the range check uses the full address.
  assign wr_in_range = aw_addr_q < ADDR_LIMIT;
  assign rd_in_range = ARADDR    < ADDR_LIMIT;
  assign wr_idx      = aw_addr_q[2 +: IDX_W];
  assign rd_idx      = ARADDR[2 +: IDX_W];

  // Latch the AW and W halves independently; release both on commit.
  always_ff @(posedge ACLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, which is what gives reads the pre-write value.
    if (ARESET) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= AWADDR;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= WDATA;
        w_strb_q <= WSTRB;
      end
    end
  end

  // Write response: raised on commit, held until the master takes it.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  // Register bank update with per-byte strobes, plus the post-commit write pulse.
  always_ff @(posedge ACLK) begin
    // NOTE: the register array is explicitly reset because software expects
    // every register to read zero after reset, so it cannot map to plain RAM.
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_wr_q[i] <= commit && wr_in_range && (wr_idx == IDX_W'(i));
        if (commit && wr_in_range && (wr_idx == IDX_W'(i))) begin
          for (int k = 0; k < STRB_W; k++) begin
            if (w_strb_q[k]) regs[i][8*k +: 8] <= w_data_q[8*k +: 8];
          end
        end
      end
    end
  end

  // Read path: capture on AR handshake, hold until R handshake, then clear data.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_in_range ? regs[rd_idx] : '0;
      rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end
  end

  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign REG_OUT[g*REG_WIDTH +: REG_WIDTH] = regs[g];
    end
  endgenerate

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;
  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;
  assign RRESP  = rresp_q;
  assign REG_WR = reg_wr_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Scoreboard bench for axi_lite_slave_regs: write/read expectations are queued
// when stimulus is driven and popped by monitors when B/R handshakes occur.
module tb_axi_lite_slave_regs;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [31:0]  AWADDR = '0;
  logic         AWVALID = 1'b0;
  logic         AWREADY;
  logic [31:0]  WDATA = '0;
  logic [3:0]   WSTRB = '0;
  logic         WVALID = 1'b0;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY = 1'b1;
  logic [31:0]  ARADDR = '0;
  logic         ARVALID = 1'b0;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY = 1'b1;
  logic [127:0] REG_OUT;
  logic [3:0]   REG_WR;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] model [4];
  logic [1:0]  b_q [$];
  rexp_t       r_q [$];

  axi_lite_slave_regs #(.REG_WIDTH(32), .NUM_REGS(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .REG_OUT(REG_OUT), .REG_WR(REG_WR)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  // B channel monitor: pop expected response on each B handshake.
  always @(negedge ACLK) begin
    if (!ARESET && BVALID && BREADY) begin
      checks++;
      if (b_q.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got BRESP=%b with no write outstanding", BRESP);
      end else begin
        logic [1:0] exp_b;
        exp_b = b_q.pop_front();
        if (BRESP !== exp_b) begin
          errors++;
          $display("FAIL bresp: got %b expected %b", BRESP, exp_b);
        end
      end
    end
  end

  // R channel monitor: pop expected data/response on each R handshake.
  always @(negedge ACLK) begin
    if (!ARESET && RVALID && RREADY) begin
      checks++;
      if (r_q.size() == 0) begin
        errors++;
        $display("FAIL r_unexpected: got RDATA=%h with no read outstanding", RDATA);
      end else begin
        rexp_t exp_r;
        exp_r = r_q.pop_front();
        if (RDATA !== exp_r.data || RRESP !== exp_r.resp) begin
          errors++;
          $display("FAIL rdata: got %h/%b expected %h/%b", RDATA, RRESP, exp_r.data, exp_r.resp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic send_aw(input logic [31:0] a);
    bit ok = 0;
    AWADDR = a; AWVALID = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge ACLK); ok = AWREADY;
      @(posedge ACLK); #1;
    end
    AWVALID = 1'b0;
    if (!ok) begin errors++; checks++; $display("FAIL aw_timeout: AWREADY=0 expected 1"); end
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge ACLK); ok = WREADY;
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0;
    if (!ok) begin errors++; checks++; $display("FAIL w_timeout: WREADY=0 expected 1"); end
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit ok = 0;
    ARADDR = a; ARVALID = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge ACLK); ok = ARREADY;
      @(posedge ACLK); #1;
    end
    ARVALID = 1'b0;
    if (!ok) begin errors++; checks++; $display("FAIL ar_timeout: ARREADY=0 expected 1"); end
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] idx;
    idx = a[3:2];
    b_q.push_back(a < 32'd16 ? 2'b00 : 2'b10);
    if (a < 32'd16)
      for (int k = 0; k < 4; k++) if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    expect_write(a, d, s);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  task automatic expect_read(input logic [31:0] a);
    rexp_t e;
    logic [1:0] idx;
    idx = a[3:2];
    e.data = (a < 32'd16) ? model[idx] : 32'h0;
    e.resp = (a < 32'd16) ? 2'b00 : 2'b10;
    r_q.push_back(e);
  endtask

  task automatic read_txn(input logic [31:0] a);
    expect_read(a);
    send_ar(a);
  endtask

  task automatic drain();
    int n = 0;
    while ((b_q.size() != 0 || r_q.size() != 0) && n < 30) begin
      @(posedge ACLK); #1;
      n++;
    end
    checks++;
    if (b_q.size() != 0 || r_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: outstanding b=%0d r=%0d expected 0", b_q.size(), r_q.size());
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("reset_valids", {BVALID, RVALID, BRESP, RRESP}, 6'b0);
    chk("reset_rdata", RDATA, 32'h0);
    chk("reset_reg_out", REG_OUT, 128'h0);
    chk("reset_reg_wr", REG_WR, 4'h0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    @(negedge ACLK);
    chk("post_reset_readys", {AWREADY, WREADY, ARREADY}, 3'b111);
    @(posedge ACLK); #1;
  endtask

  task automatic test_basic_write();
    write_txn(32'h4, 32'hDEADBEEF, 4'hF);
    @(negedge ACLK);
    chk("basic_bvalid_early", BVALID, 1'b0);
    @(negedge ACLK);
    chk("basic_bvalid", BVALID, 1'b1);
    chk("basic_reg1", REG_OUT[63:32], 32'hDEADBEEF);
    chk("basic_reg_wr", REG_WR, 4'b0010);
    @(negedge ACLK);
    chk("basic_reg_wr_clear", REG_WR, 4'b0000);
    chk("basic_bvalid_clear", BVALID, 1'b0);
    @(posedge ACLK); #1;
    read_txn(32'h4);
    drain();
    @(negedge ACLK);
    chk("basic_rdata_cleared", {RVALID, RDATA}, 33'h0);
    @(posedge ACLK); #1;
  endtask

  task automatic test_w_before_aw();
    expect_write(32'h8, 32'h12345678, 4'b0101);
    send_w(32'h12345678, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("wfirst_wready_low", {WREADY, BVALID}, 2'b00);
      if (i < 2) begin @(posedge ACLK); #1; end
    end
    @(posedge ACLK); #1;
    send_aw(32'h8);
    @(negedge ACLK);
    chk("wfirst_bvalid_early", BVALID, 1'b0);
    @(negedge ACLK);
    chk("wfirst_bvalid", BVALID, 1'b1);
    chk("wfirst_reg2", REG_OUT[95:64], 32'h00340078);
    @(posedge ACLK); #1;
    drain();
    read_txn(32'h8);
    drain();
  endtask

  task automatic test_out_of_range();
    write_txn(32'h40, 32'hFFFFFFFF, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("oor_reg_wr", REG_WR, 4'h0);
    end
    @(posedge ACLK); #1;
    drain();
    chk("oor_reg_out", REG_OUT, model_flat());
    read_txn(32'h40);
    drain();
  endtask

  task automatic test_bready_stall();
    BREADY = 1'b0;
    write_txn(32'hC, 32'h0BADF00D, 4'hF);
    @(negedge ACLK);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("stall_b_hold", {BVALID, BRESP, AWREADY, WREADY}, 5'b10000);
    end
    @(posedge ACLK); #1;
    BREADY = 1'b1;
    drain();
    @(negedge ACLK);
    chk("stall_release", {BVALID, AWREADY, WREADY}, 3'b011);
    chk("stall_reg3", REG_OUT[127:96], 32'h0BADF00D);
    @(posedge ACLK); #1;
  endtask

  task automatic test_read_during_commit();
    int c_wr, c_rd;
    write_txn(32'h0, 32'h11111111, 4'hF);
    drain();
    b_q.push_back(2'b00);
    fork
      send_aw(32'h0);
      send_w(32'hA5A5A5A5, 4'hF);
    join
    c_wr = cyc;
    expect_read(32'h0);
    model[0] = 32'hA5A5A5A5;
    send_ar(32'h0);
    c_rd = cyc;
    chk("rdc_same_edge", c_rd - c_wr, 1);
    drain();
    read_txn(32'h0);
    drain();
  endtask

  task automatic test_back_to_back();
    int c [3];
    for (int i = 0; i < 3; i++) begin
      write_txn(32'(i * 4), 32'hC0DE0000 + 32'(i), 4'hF);
      c[i] = cyc;
    end
    chk("b2b_gap1", c[1] - c[0], 3);
    chk("b2b_gap2", c[2] - c[1], 3);
    drain();
    chk("b2b_reg_out", REG_OUT, model_flat());
  endtask

  task automatic test_reset_mid();
    RREADY = 1'b0;
    expect_read(32'h4);
    send_ar(32'h4);
    send_aw(32'h4);
    @(negedge ACLK);
    chk("mid_pre_rvalid", RVALID, 1'b1);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    b_q.delete();
    r_q.delete();
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    RREADY = 1'b1;
    @(negedge ACLK);
    chk("mid_rvalid", RVALID, 1'b0);
    chk("mid_reg_out", REG_OUT, 128'h0);
    @(posedge ACLK); #1;
    send_w(32'hCAFE0001, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("mid_no_bvalid", BVALID, 1'b0);
    end
    @(posedge ACLK); #1;
    expect_write(32'h4, 32'hCAFE0001, 4'hF);
    send_aw(32'h4);
    drain();
    chk("mid_reg_out_after", REG_OUT, model_flat());
    read_txn(32'h4);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_w_before_aw();
    test_out_of_range();
    test_bready_stall();
    test_read_during_commit();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge ACLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
